// File: rtl/sc_frame_sequencer.sv
// Per-frame walker: reads each ball position, drives the shared world-to-screen
// converter and hands the screen coordinates to the renderer over valid/ready.
module sc_frame_sequencer #(
  parameter int WIDTH   = 32,
  parameter int N_BALLS = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       res_y,
  output logic              busy,
  output logic              done,
  output logic              pos_rd,
  output logic [ADDR_W-1:0] pos_addr,
  input  logic [WIDTH-1:0]  pos_x,
  input  logic [WIDTH-1:0]  pos_y,
  output logic [WIDTH-1:0]  cv_x,
  output logic [WIDTH-1:0]  cv_y,
  output logic [10:0]       cv_res_y,
  input  logic [10:0]       cv_x_sc,
  input  logic [10:0]       cv_y_sc,
  output logic              sc_valid,
  input  logic              sc_ready,
  output logic [ADDR_W-1:0] sc_addr,
  output logic [10:0]       sc_x,
  output logic [10:0]       sc_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_CONV, S_WRITE, S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BALLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [10:0]       res_y_q, res_y_d;
  logic [WIDTH-1:0]  cv_x_q, cv_x_d;
  logic [WIDTH-1:0]  cv_y_q, cv_y_d;
  logic [10:0]       sc_x_q, sc_x_d;
  logic [10:0]       sc_y_q, sc_y_d;
  logic [ADDR_W-1:0] sc_addr_q, sc_addr_d;
  logic              sc_valid_q, sc_valid_d;

  logic last_entry;
  assign last_entry = (index_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      res_y_q    <= '0;
      cv_x_q     <= '0;
      cv_y_q     <= '0;
      sc_x_q     <= '0;
      sc_y_q     <= '0;
      sc_addr_q  <= '0;
      sc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      res_y_q    <= res_y_d;
      cv_x_q     <= cv_x_d;
      cv_y_q     <= cv_y_d;
      sc_x_q     <= sc_x_d;
      sc_y_q     <= sc_y_d;
      sc_addr_q  <= sc_addr_d;
      sc_valid_q <= sc_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_CONV;
      S_CONV:  state_d = S_WRITE;
      S_WRITE: if (sc_ready) state_d = last_entry ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers only move in the state that owns them; everything else holds.
  always_comb begin
    index_d    = index_q;
    res_y_d    = res_y_q;
    cv_x_d     = cv_x_q;
    cv_y_d     = cv_y_q;
    sc_x_d     = sc_x_q;
    sc_y_d     = sc_y_q;
    sc_addr_d  = sc_addr_q;
    sc_valid_d = sc_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          res_y_d = res_y;
          index_d = '0;
        end
      end
      S_LATCH: begin
        cv_x_d = pos_x;
        cv_y_d = pos_y;
      end
      S_CONV: begin
        sc_x_d     = cv_x_sc;
        sc_y_d     = cv_y_sc;
        sc_addr_d  = index_q;
        sc_valid_d = 1'b1;
      end
      S_WRITE: begin
        if (sc_ready) begin
          sc_valid_d = 1'b0;
          if (!last_entry) index_d = index_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    pos_rd   = (state_q == S_READ);
    pos_addr = index_q;
  end

  assign cv_x     = cv_x_q;
  assign cv_y     = cv_y_q;
  assign cv_res_y = res_y_q;
  assign sc_valid = sc_valid_q;
  assign sc_addr  = sc_addr_q;
  assign sc_x     = sc_x_q;
  assign sc_y     = sc_y_q;

endmodule

// File: tb/tb_sc_frame_sequencer.sv
// Directed bench for sc_frame_sequencer with a position-table model and a
// behavioural world-to-screen converter.
module tb_sc_frame_sequencer;
  localparam int WIDTH   = 32;
  localparam int N_BALLS = 16;
  localparam int ADDR_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, sc_ready;
  logic [10:0]       res_y;
  logic              busy, done, pos_rd, sc_valid;
  logic [ADDR_W-1:0] pos_addr, sc_addr;
  logic [WIDTH-1:0]  pos_x, pos_y, cv_x, cv_y;
  logic [10:0]       cv_res_y, cv_x_sc, cv_y_sc, sc_x, sc_y;

  sc_frame_sequencer #(.WIDTH(WIDTH), .N_BALLS(N_BALLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .res_y(res_y),
    .busy(busy), .done(done), .pos_rd(pos_rd), .pos_addr(pos_addr),
    .pos_x(pos_x), .pos_y(pos_y), .cv_x(cv_x), .cv_y(cv_y),
    .cv_res_y(cv_res_y), .cv_x_sc(cv_x_sc), .cv_y_sc(cv_y_sc),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_addr(sc_addr),
    .sc_x(sc_x), .sc_y(sc_y)
  );

  // Position table: registered read, data valid the cycle after pos_rd.
  logic [WIDTH-1:0] mem_x [N_BALLS];
  logic [WIDTH-1:0] mem_y [N_BALLS];
  initial begin
    pos_x = '0;
    pos_y = '0;
  end
  always @(posedge clk) begin
    if (pos_rd) begin
      pos_x <= mem_x[pos_addr];
      pos_y <= mem_y[pos_addr];
    end
  end

  // Converter: floor(2*v*res_y / 2^(WIDTH-1)) truncated to 11 bits.
  logic [63:0] prod_x, prod_y;
  assign prod_x  = 64'(cv_x) * 64'(cv_res_y);
  assign prod_y  = 64'(cv_y) * 64'(cv_res_y);
  assign cv_x_sc = prod_x[WIDTH+8:WIDTH-2];
  assign cv_y_sc = prod_y[WIDTH+8:WIDTH-2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int busy_cnt = 0;
  int done_cnt = 0;
  int wq_addr[$];
  int wq_x[$];
  int wq_y[$];
  int rd_cyc_q[$];
  int vrise_q[$];
  logic prev_v = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (pos_rd) rd_cyc_q.push_back(cyc);
    if (sc_valid && !prev_v) vrise_q.push_back(cyc);
    if (sc_valid && sc_ready) begin
      wq_addr.push_back(int'(sc_addr));
      wq_x.push_back(int'(sc_x));
      wq_y.push_back(int'(sc_y));
    end
    prev_v = sc_valid;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_x(input int i);
    case (i)
      0:       return 800;
      1:       return 1279;
      2:       return 0;
      default: return i * 50;
    endcase
  endfunction

  function automatic int exp_y(input int i);
    case (i)
      0:       return 400;
      1:       return 0;
      2:       return 800;
      default: return (16 - i) * 50;
    endcase
  endfunction

  task automatic check_writes(input string pass, input int base);
    check_val({pass, "_write_count"}, 64'(wq_addr.size() - base), 64'(N_BALLS));
    for (int i = 0; i < N_BALLS; i++) begin
      if (base + i < wq_addr.size()) begin
        check_val($sformatf("%s_addr%0d", pass, i), 64'(wq_addr[base+i]), 64'(i));
        check_val($sformatf("%s_x%0d", pass, i), 64'(wq_x[base+i]), 64'(exp_x(i)));
        check_val($sformatf("%s_y%0d", pass, i), 64'(wq_y[base+i]), 64'(exp_y(i)));
      end
    end
  endtask

  task automatic wait_done(input string pass, input int lim);
    int g;
    g = 0;
    while (!done && g < lim) begin
      @(negedge clk);
      g++;
    end
    check_val({pass, "_done_seen"}, 64'(done), 64'(1));
  endtask

  int k, b_busy, b_done, b_w, b_rd, b_v, g;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    res_y    = 11'd800;
    sc_ready = 1'b1;
    mem_x[0] = 32'h4000_0000; mem_y[0] = 32'h2000_0000;
    mem_x[1] = 32'h6666_6666; mem_y[1] = 32'h0000_0000;
    mem_x[2] = 32'h0000_0000; mem_y[2] = 32'h4000_0000;
    for (int i = 3; i < N_BALLS; i++) begin
      mem_x[i] = 32'(i) << 26;
      mem_y[i] = 32'(16 - i) << 26;
    end

    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_done", 64'(done), 0);
    check_val("rst_pos_rd", 64'(pos_rd), 0);
    check_val("rst_sc_valid", 64'(sc_valid), 0);
    check_val("rst_pos_addr", 64'(pos_addr), 0);
    check_val("rst_sc_addr", 64'(sc_addr), 0);
    check_val("rst_sc_xy", {32'(sc_x), 32'(sc_y)}, 0);
    check_val("rst_cv_xy", {cv_x, cv_y}, 0);
    check_val("rst_cv_res_y", 64'(cv_res_y), 0);

    start = 1'b0;
    rst_n = 1'b1;
    b_busy = busy_cnt;
    repeat (12) @(negedge clk);
    check_val("idle_busy", 64'(busy), 0);
    check_val("idle_busy_cycles", 64'(busy_cnt - b_busy), 0);

    // Pass A: ready always high, stray start and res_y change mid-pass.
    k = cyc; b_busy = busy_cnt; b_done = done_cnt; b_w = wq_addr.size();
    b_rd = rd_cyc_q.size(); b_v = vrise_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    res_y = 11'd600;
    @(negedge clk);
    start = 1'b0;
    wait_done("passA", 200);
    check_val("passA_done_latency", 64'(cyc - k), 65);
    repeat (4) @(negedge clk);
    check_val("passA_busy_cycles", 64'(busy_cnt - b_busy), 65);
    check_val("passA_done_pulses", 64'(done_cnt - b_done), 1);
    check_val("passA_idle_after", 64'(busy), 0);
    check_val("passA_read_count", 64'(rd_cyc_q.size() - b_rd), 16);
    if (rd_cyc_q.size() > b_rd && vrise_q.size() > b_v) begin
      check_val("passA_first_read", 64'(rd_cyc_q[b_rd] - k), 1);
      check_val("passA_valid_lat", 64'(vrise_q[b_v] - rd_cyc_q[b_rd]), 3);
    end else begin
      check_val("passA_read_valid_seen", 0, 1);
    end
    check_writes("passA", b_w);
    res_y = 11'd800;

    // Pass B: renderer stalls entry 3 for five cycles.
    b_busy = busy_cnt; b_done = done_cnt; b_w = wq_addr.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(pos_rd && pos_addr == 4'd3) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("passB_read3_seen", 64'(pos_rd && pos_addr == 4'd3), 1);
    sc_ready = 1'b0;
    g = 0;
    while (!sc_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    for (int j = 0; j < 5; j++) begin
      check_val($sformatf("stall%0d_valid", j), 64'(sc_valid), 1);
      check_val($sformatf("stall%0d_addr", j), 64'(sc_addr), 3);
      check_val($sformatf("stall%0d_xy", j), {32'(sc_x), 32'(sc_y)}, {32'd150, 32'd650});
      check_val($sformatf("stall%0d_no_rd", j), 64'(pos_rd), 0);
      @(negedge clk);
    end
    sc_ready = 1'b1;
    @(negedge clk);
    check_val("passB_resume_rd", 64'(pos_rd), 1);
    check_val("passB_resume_addr", 64'(pos_addr), 4);
    wait_done("passB", 200);
    repeat (3) @(negedge clk);
    check_val("passB_busy_cycles", 64'(busy_cnt - b_busy), 70);
    check_val("passB_done_pulses", 64'(done_cnt - b_done), 1);
    check_writes("passB", b_w);

    // Pass C: reset pulse at entry 7 aborts the pass.
    b_done = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(pos_rd && pos_addr == 4'd7) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("passC_read7_seen", 64'(pos_rd && pos_addr == 4'd7), 1);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 0);
    check_val("abort_pos_rd", 64'(pos_rd), 0);
    check_val("abort_pos_addr", 64'(pos_addr), 0);
    check_val("abort_sc", {32'(sc_valid), 32'(sc_addr)}, 0);
    check_val("abort_cv_res_y", 64'(cv_res_y), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_busy = busy_cnt; b_v = vrise_q.size();
    repeat (20) @(negedge clk);
    check_val("abort_no_done", 64'(done_cnt - b_done), 0);
    check_val("abort_busy_after", 64'(busy_cnt - b_busy), 0);
    check_val("abort_no_valid", 64'(vrise_q.size() - b_v), 0);

    // Pass D: fresh start begins at entry 0.
    b_w = wq_addr.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("passD_first_rd", 64'(pos_rd), 1);
    check_val("passD_first_addr", 64'(pos_addr), 0);
    wait_done("passD", 200);
    repeat (2) @(negedge clk);
    check_writes("passD", b_w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed 1 expected 0");
    $fatal(1, "bench timeout");
  end
endmodule
